// File: rtl/tdc_fine_encoder.sv
// Fine-time stage: synchronises the delay-chain taps, snapshots a hit, converts
// the thermometer to a binary fine code and sequences the delay-chain clear.
module tdc_fine_encoder #(
  parameter int unsigned TAPS      = 400,
  parameter int unsigned CW        = 9,
  parameter int unsigned SYNC_DP   = 2,
  parameter int unsigned CLR_HOLD  = 4,
  parameter int unsigned STUCK_LIM = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TAPS-1:0] delay_tap,
  input  logic            mode,
  output logic [CW-1:0]   fine_val,
  output logic            fine_vld,
  output logic            overflow,
  output logic            clr,
  output logic            busy,
  output logic            stuck
);
  localparam int unsigned GW        = 16;
  localparam int unsigned NG        = (TAPS + GW - 1) / GW;
  localparam int unsigned HW        = (CLR_HOLD > 2) ? $clog2(CLR_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (CLR_HOLD > 2) ? CLR_HOLD - 2 : 0;
  localparam int unsigned SW        = $clog2(STUCK_LIM + 1);

  // ENC1/ENC2 are carried by the pv shift register, not the state register,
  // so the clear sequence can run alongside the encode.
  typedef enum logic [2:0] {IDLE, CAPTURE, ENC1, ENC2, CLEAR, WAIT_LOW} state_t;

  state_t            state;
  logic [TAPS-1:0]   sync_q [SYNC_DP];
  logic [TAPS-1:0]   s;
  logic [TAPS-1:0]   snap;
  logic [NG*GW-1:0]  snap_pad;
  logic              mode_q, m1, cap;
  logic [HW-1:0]     hold_cnt;
  logic [SW-1:0]     stuck_cnt;
  logic [2:0]        pv;
  logic [4:0]        grp   [NG];
  logic [4:0]        grp_q [NG];
  logic [TAPS:0]     first_zero, fz_q;
  logic [CW-1:0]     sum, idx, enc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_DP; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= delay_tap;
      for (int unsigned i = 1; i < SYNC_DP; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s        = sync_q[SYNC_DP-1];
  assign cap      = (state == IDLE) && s[0];
  assign snap_pad = (NG*GW)'(snap);

  // Stage-1 combinational: 16-bit partial popcounts and one-hot first zero
  // (bit TAPS of first_zero marks an all-ones snapshot).
  always_comb begin
    logic run;
    run = 1'b1;
    first_zero = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      grp[g] = '0;
      for (int unsigned b = 0; b < GW; b++)
        grp[g] = grp[g] + 5'(snap_pad[g*GW+b]);
    end
    for (int unsigned i = 0; i < TAPS; i++) begin
      first_zero[i] = run & ~snap[i];
      run = run & snap[i];
    end
    first_zero[TAPS] = run;
  end

  always_comb begin
    sum = '0;
    idx = '0;
    for (int unsigned g = 0; g < NG; g++) sum = sum + CW'(grp_q[g]);
    for (int unsigned i = 0; i <= TAPS; i++)
      if (fz_q[i]) idx = idx | CW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv       <= '0;
      fz_q     <= '0;
      m1       <= 1'b0;
      enc_q    <= '0;
      fine_vld <= 1'b0;
      fine_val <= '0;
      overflow <= 1'b0;
      for (int unsigned g = 0; g < NG; g++) grp_q[g] <= '0;
    end else begin
      pv <= {pv[1:0], cap};
      if (pv[0]) begin
        for (int unsigned g = 0; g < NG; g++) grp_q[g] <= grp[g];
        fz_q <= first_zero;
        m1   <= mode_q;
      end
      if (pv[1]) enc_q <= m1 ? idx : sum;
      fine_vld <= pv[2];
      if (pv[2]) begin
        fine_val <= enc_q;
        overflow <= (enc_q == CW'(TAPS));
      end
    end
  end

  // CLEAR covers CLR_HOLD-1 cycles; the mandatory WAIT_LOW cycle completes the hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      snap     <= '0;
      mode_q   <= 1'b0;
      clr      <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (s[0]) begin
          snap   <= s;
          mode_q <= mode;
          busy   <= 1'b1;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          clr      <= 1'b1;
          hold_cnt <= '0;
          state    <= (CLR_HOLD > 1) ? CLEAR : WAIT_LOW;
        end
        CLEAR: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_cnt == HW'(HOLD_LAST)) state <= WAIT_LOW;
        end
        WAIT_LOW: if (!s[0]) begin
          clr   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_cnt <= '0;
      stuck     <= 1'b0;
    end else if (!clr) begin
      stuck_cnt <= '0;
    end else begin
      if (stuck_cnt != SW'(STUCK_LIM)) stuck_cnt <= stuck_cnt + SW'(1);
      if (stuck_cnt >= SW'(STUCK_LIM - 1) && s[0]) stuck <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_fine_encoder.sv
// Directed bench for tdc_fine_encoder: vector table for both conversion modes
// plus hand sequences for clear timing, re-arm, stuck detection and reset.
module tb_tdc_fine_encoder;
  localparam int unsigned TAPS = 400;
  localparam int unsigned CW   = 9;

  logic            clk, rst, mode;
  logic [TAPS-1:0] delay_tap;
  logic [CW-1:0]   fine_val;
  logic            fine_vld, overflow, clr, busy, stuck;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [TAPS-1:0] taps;
    logic            md;
    logic [CW-1:0]   val;
    logic            ovf;
  } vec_t;

  vec_t vecs [14];

  tdc_fine_encoder #(
    .TAPS(TAPS), .CW(CW), .SYNC_DP(2), .CLR_HOLD(4), .STUCK_LIM(64)
  ) dut (
    .clk(clk), .rst(rst), .delay_tap(delay_tap), .mode(mode),
    .fine_val(fine_val), .fine_vld(fine_vld), .overflow(overflow),
    .clr(clr), .busy(busy), .stuck(stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // Taps rise before edge k=0, so capture is at k=2, clr rises at k=3,
  // fine_vld is seen after k=5 and clr/busy drop at k=7.
  task automatic run_vec(input vec_t v);
    logic b [10];
    logic c [10];
    logic f [10];
    logic [CW-1:0] val5;
    logic ov5;
    int nv = 0;
    int nc = 0;
    val5 = '0;
    ov5  = 1'b0;
    delay_tap = v.taps;
    mode      = v.md;
    for (int k = 0; k < 10; k++) begin
      step();
      b[k] = busy; c[k] = clr; f[k] = fine_vld;
      if (k == 5) begin val5 = fine_val; ov5 = overflow; end
      if (k == 2) mode = ~v.md;
      if (k == 3) delay_tap = '0;
    end
    for (int k = 0; k < 10; k++) begin
      nv += int'(f[k]);
      nc += int'(c[k]);
    end
    chk("busy_before_capture", 32'(b[1]), 32'd0);
    chk("busy_at_capture",     32'(b[2]), 32'd1);
    chk("clr_before_rise",     32'(c[2]), 32'd0);
    chk("clr_rise",            32'(c[3]), 32'd1);
    chk("vld_timing",          32'(f[5]), 32'd1);
    chk("vld_count",           32'(nv),   32'd1);
    chk("clr_high_cycles",     32'(nc),   32'd4);
    chk("busy_drop",           32'(b[7]), 32'd0);
    chk("fine_val",            32'(val5), 32'(v.val));
    chk("overflow",            32'(ov5),  32'(v.ovf));
    chk("fine_val_held",       32'(fine_val), 32'(v.val));
    wait_idle();
    repeat (3) step();
  endtask

  initial begin : main
    logic [TAPS-1:0] one, t137, bub, allv, lo399, b0h, alt;
    logic b [21];
    logic c [21];
    logic f [21];
    logic st [71];
    logic [CW-1:0] v5, v11;
    logic o5, o11;
    int nv;

    one   = '0; one[0] = 1'b1;
    t137  = (one << 137) - one;
    bub   = ((one << 121) - one) & ~(one << 100);
    allv  = '1;
    lo399 = allv & ~(one << 399);
    b0h   = one | (one << 399);
    for (int i = 0; i < int'(TAPS); i++) alt[i] = (i % 2 == 0);

    vecs[0]  = '{t137,  1'b0, 9'd137, 1'b0};
    vecs[1]  = '{t137,  1'b1, 9'd137, 1'b0};
    vecs[2]  = '{bub,   1'b0, 9'd120, 1'b0};
    vecs[3]  = '{bub,   1'b1, 9'd100, 1'b0};
    vecs[4]  = '{allv,  1'b0, 9'd400, 1'b1};
    vecs[5]  = '{allv,  1'b1, 9'd400, 1'b1};
    vecs[6]  = '{one,   1'b0, 9'd1,   1'b0};
    vecs[7]  = '{one,   1'b1, 9'd1,   1'b0};
    vecs[8]  = '{b0h,   1'b0, 9'd2,   1'b0};
    vecs[9]  = '{b0h,   1'b1, 9'd1,   1'b0};
    vecs[10] = '{lo399, 1'b0, 9'd399, 1'b0};
    vecs[11] = '{lo399, 1'b1, 9'd399, 1'b0};
    vecs[12] = '{alt,   1'b0, 9'd200, 1'b0};
    vecs[13] = '{alt,   1'b1, 9'd1,   1'b0};

    rst = 1'b1; delay_tap = '0; mode = 1'b0;
    repeat (3) step();
    chk("rst_fine_val", 32'(fine_val), 32'd0);
    chk("rst_fine_vld", 32'(fine_vld), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_clr",      32'(clr),      32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_stuck",    32'(stuck),    32'd0);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Late tap release plus a tap change while busy: clr follows s[0], no recapture.
    delay_tap = t137; mode = 1'b0;
    for (int k = 0; k < 21; k++) begin
      step();
      b[k] = busy; c[k] = clr; f[k] = fine_vld;
      if (k == 5) v5 = fine_val;
      if (k == 4) delay_tap = allv;
      if (k == 13) delay_tap = '0;
    end
    nv = 0;
    for (int k = 0; k < 21; k++) nv += int'(f[k]);
    chk("late_clr_still_high", 32'(c[15]), 32'd1);
    chk("late_clr_fall",       32'(c[16]), 32'd0);
    chk("late_busy_high",      32'(b[15]), 32'd1);
    chk("late_busy_fall",      32'(b[16]), 32'd0);
    chk("late_vld_count",      32'(nv),    32'd1);
    chk("late_fine_val",       32'(v5),    32'd137);
    chk("late_val_held",       32'(fine_val), 32'd137);
    wait_idle();
    repeat (3) step();

    // Re-arm: IDLE at k=7, second capture at k=8; both results issue on schedule.
    delay_tap = allv; mode = 1'b0;
    v5 = '0; v11 = '0; o5 = 1'b0; o11 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      b[k] = busy; f[k] = fine_vld;
      if (k == 5) begin v5 = fine_val; o5 = overflow; end
      if (k == 11) begin v11 = fine_val; o11 = overflow; end
      if (k == 3) delay_tap = '0;
      if (k == 5) begin delay_tap = bub; mode = 1'b1; end
      if (k == 9) delay_tap = '0;
    end
    chk("rearm_idle",      32'(b[7]),  32'd0);
    chk("rearm_capture",   32'(b[8]),  32'd1);
    chk("rearm_vld1",      32'(f[5]),  32'd1);
    chk("rearm_val1",      32'(v5),    32'd400);
    chk("rearm_ovf1",      32'(o5),    32'd1);
    chk("rearm_vld2",      32'(f[11]), 32'd1);
    chk("rearm_val2",      32'(v11),   32'd100);
    chk("rearm_ovf2",      32'(o11),   32'd0);
    wait_idle();
    repeat (3) step();

    // Stuck: clr rises at k=3, so 64 clr-high cycles complete at edge k=67.
    delay_tap = one; mode = 1'b0;
    for (int k = 0; k < 71; k++) begin
      step();
      st[k] = stuck;
    end
    chk("stuck_before_lim", 32'(st[66]), 32'd0);
    chk("stuck_at_lim",     32'(st[67]), 32'd1);
    chk("stuck_clr_high",   32'(clr),    32'd1);
    delay_tap = '0;
    wait_idle();
    repeat (3) step();
    chk("stuck_sticky_idle", 32'(stuck), 32'd1);
    chk("stuck_busy_idle",   32'(busy),  32'd0);

    // Reset one cycle after capture discards the conversion.
    delay_tap = t137; mode = 1'b1;
    repeat (4) step();
    chk("rstmid_clr_before", 32'(clr), 32'd1);
    rst = 1'b1;
    delay_tap = '0;
    #1;
    chk("rstmid_clr",      32'(clr),      32'd0);
    chk("rstmid_busy",     32'(busy),     32'd0);
    chk("rstmid_vld",      32'(fine_vld), 32'd0);
    chk("rstmid_stuck",    32'(stuck),    32'd0);
    chk("rstmid_fine_val", 32'(fine_val), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      nv += int'(fine_vld);
    end
    chk("rstmid_no_vld", 32'(nv), 32'd0);
    run_vec(vecs[3]);
    run_vec(vecs[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
